spi_slave: RTL and testbench

- 8-bit SPI slave shift register, LSB-first, full-duplex.
- After a synchronous reset it holds a preloaded byte. The byte is shifted out on MISO while the master's byte is shifted in from MOSI.
- After 8 clocks with chip select active, the slave register holds the master's byte and the master holds the slave's preload.
- Sits at the peripheral side of the SPI link; clk is the SPI serial clock.

---
 rtl/spi_slave.sv | 94 +++++++++
 tb/tb_spi_slave.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Purpose:
//   Full-duplex SPI slave shift register that shifts the least significant bit
//   first. After reset the register holds initialValue. Each selected rising
//   edge shifts MOSI in at the MSB and drops the LSB, which has already been
//   presented on MISO. After DATA_W selected edges the slave holds the
//   master's word and the master has received the preload.
//   clk is the SPI serial clock itself, so the whole block lives in the SCK
//   domain.
//
// Ports:
//   clk             in   1       SPI serial clock; all state changes on rising edge
//   reset           in   1       synchronous reset, active low
//   cs              in   1       chip select, active low
//   MOSI            in   1       serial data from master
//   MISO            out  1       serial data to master (sreg[0] while selected)
//   initialValue    in   DATA_W  word loaded into the shift register on reset
//   slaveDataToSend out  DATA_W  current shift register contents
//   done            out  1       one-cycle pulse after the DATA_W-th shift of a frame
//
// Parameters:
//   DATA_W  shift register width / bits per frame (must be >= 2)
//
// Build option:
//   SPI_SLAVE_MISO_TRISTATE_EN  when defined, MISO floats (1'bz) while
//                               deselected so several slaves can share the
//                               line; otherwise MISO drives 0 while deselected.
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] initialValue,
  output logic [DATA_W-1:0] slaveDataToSend,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              done_q, done_d;

  // Next-state logic. The counter only tracks consecutive selected edges;
  // deselecting discards the partial count but keeps the shifted bits.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = '0;
    done_d = 1'b0;
    if (!cs) begin
      sreg_d = {MOSI, sreg_q[DATA_W-1:1]};
      if (cnt_q == CNT_LAST) begin
        // Last bit of the frame: wrap so back-to-back frames need no gap.
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset wins over chip select and shifting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_q <= initialValue;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign slaveDataToSend = sreg_q;
  assign done            = done_q;

  // MISO is combinational from sreg[0], so the next bit is visible right after
  // reset and after every shift, ready for the master to sample before the
  // following rising edge.
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = cs ? 1'bz : sreg_q[0];
`else
  assign MISO = cs ? 1'b0 : sreg_q[0];
`endif

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       MOSI;
  wire        MISO;
  logic [7:0] initialValue;
  logic [7:0] slaveDataToSend;
  logic       done;

  int vec_cnt;
  int err_cnt;

  spi_slave #(.DATA_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .MOSI            (MOSI),
    .MISO            (MISO),
    .initialValue    (initialValue),
    .slaveDataToSend (slaveDataToSend),
    .done            (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reset for one rising edge with cs high, then release. Returns at a negedge.
  task automatic do_reset(input logic [7:0] init);
    @(negedge clk);
    reset        = 1'b0;
    cs           = 1'b1;
    MOSI         = 1'b0;
    initialValue = init;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Master side: n bits LSB first. MISO is captured on the falling edge before
  // each rising edge; done is recorded after each rising edge.
  task automatic shift_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx, output logic [7:0] dmask);
    rx    = '0;
    dmask = '0;
    for (int i = 0; i < n; i++) begin
      cs   = 1'b0;
      MOSI = tx[i];
      #1;
      rx[i] = MISO;
      @(negedge clk);
      dmask[i] = done;
    end
  endtask

  logic [7:0] rx, rx2, dm, dm2;
  logic [7:0] sweep_init [8] = '{8'h0F, 8'h31, 8'h0E, 8'h07, 8'hFE, 8'h6D, 8'h01, 8'h5E};
  logic [7:0] sweep_mst  [8] = '{8'hF0, 8'h1A, 8'hC1, 8'h02, 8'h1A, 8'h91, 8'hFE, 8'h70};
  logic [31:0] miso_idle;

  initial begin
    vec_cnt      = 0;
    err_cnt      = 0;
    reset        = 1'b0;
    cs           = 1'b1;
    MOSI         = 1'b0;
    initialValue = 8'h00;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    miso_idle = {31'b0, 1'bz};
`else
    miso_idle = 32'h0;
`endif

    // Basic exchange
    do_reset(8'h09);
    check("rst_sreg", 32'(slaveDataToSend), 32'h09);
    check("rst_done", 32'(done), 32'h0);
    check("idle_miso", {31'b0, MISO}, miso_idle);
    shift_bits(8'h82, 8, rx, dm);
    check("basic_rx", 32'(rx), 32'h09);
    check("basic_sreg", 32'(slaveDataToSend), 32'h82);
    check("basic_done", 32'(dm), 32'h80);
    cs = 1'b1;
    @(negedge clk);
    check("basic_done_off", 32'(done), 32'h0);
    check("basic_hold", 32'(slaveDataToSend), 32'h82);
    check("desel_miso", {31'b0, MISO}, miso_idle);
    $display("basic: init=09 mosi=82 rx=%h sreg=%h", rx, slaveDataToSend);

    // Pattern sweep
    for (int k = 0; k < 8; k++) begin
      do_reset(sweep_init[k]);
      shift_bits(sweep_mst[k], 8, rx, dm);
      check("sweep_rx", 32'(rx), 32'(sweep_init[k]));
      check("sweep_sreg", 32'(slaveDataToSend), 32'(sweep_mst[k]));
      check("sweep_done", 32'(dm), 32'h80);
      $display("sweep %0d: init=%h mosi=%h rx=%h sreg=%h", k, sweep_init[k], sweep_mst[k], rx, slaveDataToSend);
    end

    // Reset mid-frame: 0xA5 shifted 3 times with MOSI=0 -> 0x14
    do_reset(8'hA5);
    shift_bits(8'h00, 3, rx, dm);
    check("midrst_part", 32'(slaveDataToSend), 32'h14);
    reset = 1'b0;
    cs    = 1'b0;
    @(negedge clk);
    check("midrst_sreg", 32'(slaveDataToSend), 32'hA5);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_miso", {31'b0, MISO}, 32'h1);
    reset = 1'b1;
    shift_bits(8'h3B, 8, rx, dm);
    check("midrst_rx", 32'(rx), 32'hA5);
    check("midrst_sreg2", 32'(slaveDataToSend), 32'h3B);
    check("midrst_cnt", 32'(dm), 32'h80);
    $display("midreset: rx=%h sreg=%h donemask=%h", rx, slaveDataToSend, dm);

    // cs deselect mid-frame: 0x5A with 4 bits of 0xC -> 0xC5
    do_reset(8'h5A);
    shift_bits(8'h0C, 4, rx, dm);
    check("desel_rx", 32'(rx), 32'h0A);
    check("desel_part", 32'(slaveDataToSend), 32'hC5);
    check("desel_dm", 32'(dm), 32'h00);
    cs = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("desel_hold", 32'(slaveDataToSend), 32'hC5);
      check("desel_done", 32'(done), 32'h0);
    end
    shift_bits(8'h96, 8, rx, dm);
    check("resel_rx", 32'(rx), 32'hC5);
    check("resel_sreg", 32'(slaveDataToSend), 32'h96);
    check("resel_done", 32'(dm), 32'h80);
    $display("deselect: rx=%h sreg=%h donemask=%h", rx, slaveDataToSend, dm);

    // Back-to-back frames
    do_reset(8'h3C);
    shift_bits(8'h55, 8, rx, dm);
    shift_bits(8'hAA, 8, rx2, dm2);
    check("b2b_rx1", 32'(rx), 32'h3C);
    check("b2b_rx2", 32'(rx2), 32'h55);
    check("b2b_sreg", 32'(slaveDataToSend), 32'hAA);
    check("b2b_done1", 32'(dm), 32'h80);
    check("b2b_done2", 32'(dm2), 32'h80);
    $display("b2b: rx1=%h rx2=%h sreg=%h", rx, rx2, slaveDataToSend);

    cs = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
